// File: rtl/ft_recovery_ctrl.sv
// Fault-tolerant recovery controller: halts both cores and replays every golden
// register word into them. Define FT_RECOVERY_CNT_EN to add the err_count_o output.
module ft_recovery_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  fetch_block_i,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic                  halt_o,
  output logic                  restore_we_o,
  output logic [ADDR_WIDTH-1:0] restore_addr_o,
  output logic [DATA_WIDTH-1:0] restore_data_o,
  input  logic                  restore_ready_i,
  output logic                  done_o
`ifdef FT_RECOVERY_CNT_EN
  ,
  output logic [7:0]            err_count_o
`endif
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    READ  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e                  state_r, state_s;
  logic [ADDR_WIDTH-1:0]   cnt_r, cnt_s;
  logic                    pending_r, pending_s;
  logic                    load_s;
  logic                    enter_halt_s;
  logic                    halt_r, we_r, done_r;
  logic [ADDR_WIDTH-1:0]   raddr_r;
  logic [DATA_WIDTH-1:0]   rdata_r;

  // Next-state, counter and pending-request logic.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    pending_s = pending_r;
    load_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (fetch_block_i) state_s = HALT;
        else               state_s = IDLE;
      end
      HALT: begin
        cnt_s   = {ADDR_WIDTH{1'b0}};
        state_s = READ;
      end
      READ: begin
        load_s  = 1'b1;
        state_s = WRITE;
      end
      WRITE: begin
        if (restore_ready_i) begin
          if (cnt_r == LAST_ADDR) begin
            state_s = DONE;
          end else begin
            cnt_s   = cnt_r + ADDR_ONE;
            state_s = READ;
          end
        end else begin
          state_s = WRITE;
        end
      end
      DONE: begin
        // A request arriving during DONE counts as pending too.
        if (pending_r || fetch_block_i) state_s = HALT;
        else                            state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    enter_halt_s = (state_s == HALT);
    if (enter_halt_s) begin
      pending_s = 1'b0;
    end else if (fetch_block_i && (state_r != IDLE)) begin
      pending_s = 1'b1;
    end else begin
      pending_s = pending_r;
    end
  end

  // State, counter and registered Moore outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r   <= IDLE;
      cnt_r     <= {ADDR_WIDTH{1'b0}};
      pending_r <= 1'b0;
      halt_r    <= 1'b0;
      we_r      <= 1'b0;
      done_r    <= 1'b0;
      raddr_r   <= {ADDR_WIDTH{1'b0}};
      rdata_r   <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      pending_r <= pending_s;
      halt_r    <= (state_s != IDLE);
      we_r      <= (state_s == WRITE);
      done_r    <= (state_s == DONE);
      if (load_s) begin
        raddr_r <= cnt_r;
        rdata_r <= rd_data_i;
      end else begin
        raddr_r <= raddr_r;
        rdata_r <= rdata_r;
      end
    end
  end

`ifdef FT_RECOVERY_CNT_EN
  logic [7:0] err_cnt_r;

  // Saturating count of recovery walks started.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_r <= 8'd0;
    end else if (enter_halt_s && (err_cnt_r != 8'hFF)) begin
      err_cnt_r <= err_cnt_r + 8'd1;
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign err_count_o = err_cnt_r;
`endif

  assign rd_addr_o      = cnt_r;
  assign halt_o         = halt_r;
  assign restore_we_o   = we_r;
  assign restore_addr_o = raddr_r;
  assign restore_data_o = rdata_r;
  assign done_o         = done_r;

endmodule

// File: doc/ft_recovery_ctrl.md
FT_RECOVERY_CTRL -- requirements
Module: ft_recovery_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 5, sets the register-file address width; the block walks 2**ADDR_WIDTH words.
REQ-002 Parameter DATA_WIDTH, default 32, sets the register word width.
REQ-003 clk_i  in  1  single clock; all state is updated on the rising edge.
REQ-004 rst_ni  in  1  asynchronous, active-low reset.
REQ-005 fetch_block_i  in  1  mismatch/stall request from the upstream fault-tolerant write checker.
REQ-006 rd_addr_o  out  ADDR_WIDTH  read address to the golden register store.
REQ-007 rd_data_i  in  DATA_WIDTH  golden word; a combinational function of rd_addr_o within the same cycle.
REQ-008 halt_o  out  1  stalls both redundant cores.
REQ-009 restore_we_o  out  1  restore write valid.
REQ-010 restore_addr_o  out  ADDR_WIDTH  restore write address.
REQ-011 restore_data_o  out  DATA_WIDTH  restore write data.
REQ-012 restore_ready_i  in  1  the cores accept a restore write in any cycle where restore_we_o and restore_ready_i are both 1.
REQ-013 done_o  out  1  one-cycle pulse when recovery completes.

Function
REQ-014 The block SHALL implement a Moore FSM with states IDLE, HALT, READ, WRITE and DONE; every output SHALL derive from registers only.
REQ-015 In IDLE, fetch_block_i=1 sampled at a rising edge SHALL move the FSM to HALT; fetch_block_i=0 SHALL hold IDLE.
REQ-016 HALT SHALL last exactly one cycle, clear the address counter to 0, and then move to READ.
REQ-017 READ SHALL drive rd_addr_o with the counter, register rd_data_i into restore_data_o and the counter into restore_addr_o at the end of the cycle, and then move to WRITE.
REQ-018 WRITE SHALL hold restore_we_o=1 with stable restore_addr_o and restore_data_o until the cycle in which restore_ready_i=1.
REQ-019 On that handshake, if the counter equals 2**ADDR_WIDTH-1 the FSM SHALL go to DONE; otherwise the counter SHALL increment and the FSM SHALL go to READ.
REQ-020 The counter SHALL never wrap during a walk.
REQ-021 DONE SHALL last one cycle with done_o=1, and then go to HALT if a pending request exists or to IDLE otherwise.
REQ-022 halt_o SHALL be 1 in every state except IDLE.
REQ-023 restore_we_o SHALL be 1 only in WRITE.
REQ-024 fetch_block_i=1 in any non-IDLE state SHALL set a pending flag; entering HALT SHALL clear that flag.
REQ-025 With restore_ready_i held at 1, halt_o SHALL be high for exactly 2*2**ADDR_WIDTH+2 cycles (66 for ADDR_WIDTH=5).
REQ-026 rd_addr_o SHALL equal the counter in every state.

Reset
REQ-027 rst_ni=0 SHALL immediately force the FSM to IDLE and clear the counter, the pending flag, rd_addr_o, restore_addr_o, restore_data_o, restore_we_o, halt_o, done_o and err_count_o to 0, including mid-walk.
REQ-028 After rst_ni returns to 1, the first fetch_block_i sample SHALL behave as in IDLE.

Configuration
REQ-029 With FT_RECOVERY_CNT_EN defined, the block SHALL add output err_count_o (8 bits), which increments on each IDLE->HALT or DONE->HALT transition and saturates at 255.
REQ-030 Without FT_RECOVERY_CNT_EN, the port and the counter SHALL be absent, with all other behaviour identical.

Verification
REQ-031 Reset then fetch_block_i held at 0 for 20 cycles -> halt_o=0, restore_we_o=0, done_o=0 throughout.
REQ-032 Store word i=i*10, restore_ready_i=1, 1-cycle fetch_block_i pulse -> 32 writes (addr i, data i*10) in ascending order, halt_o high for 66 cycles, one done_o pulse.
REQ-033 restore_ready_i=0 for 3 cycles at addr 10 -> restore_we_o held with addr 10 and data 100 for 4 cycles; walk completes in 69 halt cycles.
REQ-034 fetch_block_i pulse at addr 20 mid-walk -> after done_o the FSM re-enters HALT and a second full walk follows; err_count_o=2 with the macro.
REQ-035 rst_ni low at addr 15 -> all outputs 0 immediately; a new request restarts the walk from addr 0.
